// File: rtl/lamp_ramp_ctrl.sv
// Soft-start lamp controller: derives a target lamp count from time code, room size and user level,
// then ramps the driven count one lamp per RAMP_DIV clocks. Optional idle auto-off: LAMP_MOTION_TIMEOUT_EN.
module lamp_ramp_ctrl #(
  parameter int LEN_W     = 4,
  parameter int LAMP_W    = 4,
  parameter int MAX_LAMPS = 12,
  parameter int RAMP_DIV  = 8,
  parameter int TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        tcode,
  input  logic [LEN_W-1:0]  lenght,
  input  logic [LAMP_W-1:0] ulight,
  input  logic              ovr_valid,
  input  logic [LAMP_W-1:0] ovr_val,
  input  logic              motion,
  output logic [LAMP_W-1:0] active_lights,
  output logic [LAMP_W-1:0] target,
  output logic              ramping,
  output logic              settled,
  output logic              ovr_active
);

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [LAMP_W-1:0] MAX_L    = LAMP_W'(MAX_LAMPS);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;

  function automatic logic [LAMP_W-1:0] sat_lamps(input logic [LAMP_W-1:0] v);
    return (v > MAX_L) ? MAX_L : v;
  endfunction

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [LAMP_W-1:0] active_q, active_d;
  logic [LAMP_W-1:0] target_q, target_d;
  logic              settled_q, settled_d;
  logic              ramping_q, ramping_d;
  logic              ovr_active_q, ovr_active_d;
  logic [3:0]        tcode_st_q, tcode_st_d;
  logic [LEN_W-1:0]  len_quarter;
  logic [LAMP_W-1:0] base_raw, base_sat;
  logic [LAMP_W-1:0] step_up, step_dn;
  logic              timed_out;

  assign len_quarter = lenght >> 2;

  // Base target from the one-hot time code; anything not one-hot means lights off.
  always_comb begin
    base_raw = '0;
    case (tcode)
      4'b0001, 4'b0010: base_raw = '0;
      4'b0100:          base_raw = LAMP_W'(len_quarter);
      4'b1000:          base_raw = ulight;
      default:          base_raw = '0;
    endcase
    base_sat = sat_lamps(base_raw);
  end

`ifdef LAMP_MOTION_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Idle counter saturates at TIMEOUT so the forced-off condition holds until motion returns.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (motion) begin
      to_cnt_d = '0;
    end else if ((active_q != '0) && (to_cnt_q != TO_LAST)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end

  assign timed_out = (to_cnt_q == TO_LAST);
`else
  logic unused_motion;
  assign unused_motion = motion;
  assign timed_out     = 1'b0;
`endif

  // Target register and sticky override; override clears when the time code moves on.
  always_comb begin
    target_d     = target_q;
    ovr_active_d = ovr_active_q;
    tcode_st_d   = tcode_st_q;
    if (timed_out) begin
      target_d     = '0;
      ovr_active_d = 1'b0;
    end else if (ovr_valid) begin
      ovr_active_d = 1'b1;
      tcode_st_d   = tcode;
      target_d     = sat_lamps(ovr_val);
    end else if (ovr_active_q) begin
      if (tcode != tcode_st_q) begin
        ovr_active_d = 1'b0;
        target_d     = base_sat;
      end else begin
        target_d     = target_q;
      end
    end else begin
      target_d = base_sat;
    end
  end

  assign step_up = active_q + LAMP_W'(1);
  assign step_dn = active_q - LAMP_W'(1);

  // Ramp FSM: one lamp per RAMP_DIV clocks; a direction change restarts the divider without stepping.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    active_d  = active_q;
    settled_d = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (target_q > active_q)      state_d = UP;
        else if (target_q < active_q) state_d = DOWN;
        else                          state_d = IDLE;
      end
      UP: begin
        if (target_q < active_q) begin
          state_d = DOWN;
          div_d   = '0;
        end else if (target_q == active_q) begin
          state_d   = IDLE;
          div_d     = '0;
          settled_d = 1'b1;
        end else if (div_q == DIV_LAST) begin
          active_d = step_up;
          div_d    = '0;
          if (step_up == target_q) begin
            state_d   = IDLE;
            settled_d = 1'b1;
          end else begin
            state_d = UP;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DOWN: begin
        if (target_q > active_q) begin
          state_d = UP;
          div_d   = '0;
        end else if (target_q == active_q) begin
          state_d   = IDLE;
          div_d     = '0;
          settled_d = 1'b1;
        end else if (div_q == DIV_LAST) begin
          active_d = step_dn;
          div_d    = '0;
          if (step_dn == target_q) begin
            state_d   = IDLE;
            settled_d = 1'b1;
          end else begin
            state_d = DOWN;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase
    ramping_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      active_q     <= '0;
      target_q     <= '0;
      settled_q    <= 1'b0;
      ramping_q    <= 1'b0;
      ovr_active_q <= 1'b0;
      tcode_st_q   <= 4'b0000;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      active_q     <= active_d;
      target_q     <= target_d;
      settled_q    <= settled_d;
      ramping_q    <= ramping_d;
      ovr_active_q <= ovr_active_d;
      tcode_st_q   <= tcode_st_d;
    end
  end

  assign active_lights = active_q;
  assign target        = target_q;
  assign ramping       = ramping_q;
  assign settled       = settled_q;
  assign ovr_active    = ovr_active_q;

endmodule

// File: tb/tb_lamp_ramp_ctrl.sv
// Directed bench for lamp_ramp_ctrl (default parameters, optional timeout feature not built).
module tb_lamp_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] tcode;
  logic [3:0] lenght;
  logic [3:0] ulight;
  logic       ovr_valid;
  logic [3:0] ovr_val;
  logic       motion;
  logic [3:0] active_lights;
  logic [3:0] target;
  logic       ramping;
  logic       settled;
  logic       ovr_active;

  int total  = 0;
  int passed = 0;

  typedef struct {
    string      name;
    logic [3:0] tc;
    logic [3:0] len;
    logic [3:0] ul;
    logic [3:0] exp_t;
  } vec_t;

  vec_t vecs[12];

  lamp_ramp_ctrl dut (
    .clk(clk), .rst(rst), .tcode(tcode), .lenght(lenght), .ulight(ulight),
    .ovr_valid(ovr_valid), .ovr_val(ovr_val), .motion(motion),
    .active_lights(active_lights), .target(target), .ramping(ramping),
    .settled(settled), .ovr_active(ovr_active)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; tcode = 4'b0000; lenght = 4'd0; ulight = 4'd0;
    ovr_valid = 1'b0; ovr_val = 4'd0; motion = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"morning",        4'b0001, 4'd13, 4'd5,  4'd0};
    vecs[1]  = '{"afternoon",      4'b0010, 4'd15, 4'd5,  4'd0};
    vecs[2]  = '{"evening_13",     4'b0100, 4'd13, 4'd5,  4'd3};
    vecs[3]  = '{"evening_15",     4'b0100, 4'd15, 4'd5,  4'd3};
    vecs[4]  = '{"evening_3",      4'b0100, 4'd3,  4'd5,  4'd0};
    vecs[5]  = '{"evening_8",      4'b0100, 4'd8,  4'd5,  4'd2};
    vecs[6]  = '{"night_7",        4'b1000, 4'd0,  4'd7,  4'd7};
    vecs[7]  = '{"night_sat15",    4'b1000, 4'd0,  4'd15, 4'd12};
    vecs[8]  = '{"night_12",       4'b1000, 4'd9,  4'd12, 4'd12};
    vecs[9]  = '{"two_hot",        4'b0110, 4'd15, 4'd15, 4'd0};
    vecs[10] = '{"zero_code",      4'b0000, 4'd15, 4'd15, 4'd0};
    vecs[11] = '{"all_hot",        4'b1111, 4'd15, 4'd15, 4'd0};

    rst = 1'b1; tcode = 4'b0000; lenght = 4'd0; ulight = 4'd0;
    ovr_valid = 1'b0; ovr_val = 4'd0; motion = 1'b0;
    #1;
    chk("rst_active",  active_lights, 0);
    chk("rst_target",  target, 0);
    chk("rst_ramping", ramping, 0);
    chk("rst_settled", settled, 0);
    chk("rst_ovr",     ovr_active, 0);
    do_reset();

    // Base target mapping, one clock latency each
    for (int i = 0; i < 12; i++) begin
      tcode = vecs[i].tc; lenght = vecs[i].len; ulight = vecs[i].ul;
      tick(1);
      chk({"tgt_", vecs[i].name}, target, vecs[i].exp_t);
    end

    // Evening ramp 0 -> 3
    do_reset();
    tcode = 4'b0100; lenght = 4'd13;
    tick(1);  chk("A_target", target, 3); chk("A_ramp_e1", ramping, 0);
    tick(1);  chk("A_ramp_e2", ramping, 1); chk("A_act_e2", active_lights, 0);
    tick(7);  chk("A_act_e9", active_lights, 0);
    tick(1);  chk("A_act_e10", active_lights, 1);
    tick(8);  chk("A_act_e18", active_lights, 2); chk("A_settled_e18", settled, 0);
    tick(8);  chk("A_act_e26", active_lights, 3); chk("A_settled_e26", settled, 1);
    chk("A_ramp_e26", ramping, 0);
    tick(1);  chk("A_settled_e27", settled, 0);

    // Night with saturated ulight: 3 -> 12
    tcode = 4'b1000; ulight = 4'd15;
    tick(1);  chk("B_target", target, 12);
    tick(72); chk("B_act_e73", active_lights, 11);
    tick(1);  chk("B_act_e74", active_lights, 12); chk("B_settled", settled, 1);
    tick(20); chk("B_hold", active_lights, 12); chk("B_ramp_off", ramping, 0);

    // Down to 6, then morning takes it to 0
    ulight = 4'd6;
    tick(49); chk("C_act_7", active_lights, 7);
    tick(1);  chk("C_act_6", active_lights, 6); chk("C_settled6", settled, 1);
    tcode = 4'b0001;
    tick(42); chk("C_act_1", active_lights, 1); chk("C_ramp_dn", ramping, 1);
    tick(8);  chk("C_act_0", active_lights, 0); chk("C_settled0", settled, 1);
    tick(1);  chk("C_settled_off", settled, 0); chk("C_ramp_off", ramping, 0);

    // Override during evening
    do_reset();
    tcode = 4'b0100; lenght = 4'd13;
    tick(26); chk("D_act_3", active_lights, 3);
    ovr_valid = 1'b1; ovr_val = 4'd5;
    tick(1);  chk("D_ovr_on", ovr_active, 1); chk("D_ovr_tgt", target, 5);
    ovr_valid = 1'b0;
    tick(17); chk("D_act_5", active_lights, 5); chk("D_settled5", settled, 1);
    chk("D_tgt_held", target, 5);
    tcode = 4'b1000; ulight = 4'd9;
    tick(1);  chk("D_ovr_off", ovr_active, 0); chk("D_tgt_ulight", target, 9);
    ovr_valid = 1'b1; ovr_val = 4'd14; tcode = 4'b0100;
    tick(1);  chk("D_ovr_tc_on", ovr_active, 1); chk("D_ovr_sat", target, 12);
    ovr_valid = 1'b0;
    tick(3);  chk("D_ovr_stored", ovr_active, 1); chk("D_tgt_stored", target, 12);
    ovr_valid = 1'b1; ovr_val = 4'd2;
    tick(1);  chk("D_reload", target, 2); chk("D_reload_on", ovr_active, 1);
    ovr_valid = 1'b0; tcode = 4'b0001;
    tick(1);  chk("D_clear", ovr_active, 0); chk("D_clear_tgt", target, 0);

    // Reversal mid-UP restarts the divider
    do_reset();
    tcode = 4'b1000; ulight = 4'd9;
    tick(18); chk("E_act_2", active_lights, 2);
    tick(3);  ulight = 4'd1;
    tick(2);  chk("E_rev_ramp", ramping, 1); chk("E_rev_act", active_lights, 2);
    tick(7);  chk("E_e9", active_lights, 2);
    tick(1);  chk("E_e10", active_lights, 1); chk("E_settled", settled, 1);
    tcode = 4'b0110;
    tick(1);  chk("E_tgt0", target, 0);
    tick(9);  chk("E_act0", active_lights, 0); chk("E_settled0", settled, 1);

    // Target meets active mid-ramp
    do_reset();
    tcode = 4'b1000; ulight = 4'd5;
    tick(20); chk("F_act_2", active_lights, 2);
    ulight = 4'd2;
    tick(1);  chk("F_tgt", target, 2); chk("F_ramp", ramping, 1);
    tick(1);  chk("F_settled", settled, 1); chk("F_idle", ramping, 0);
    chk("F_act", active_lights, 2);

    // Asynchronous reset mid-ramp
    do_reset();
    tcode = 4'b1000; ulight = 4'd9;
    tick(12); chk("G_pre_act", active_lights, 1); chk("G_pre_ramp", ramping, 1);
    rst = 1'b1;
    #2;
    chk("G_act", active_lights, 0); chk("G_tgt", target, 0);
    chk("G_ramp", ramping, 0); chk("G_settled", settled, 0);
    @(posedge clk); #1;
    rst = 1'b0; tcode = 4'b0000; ulight = 4'd0;
    tick(3);  chk("G_after_settled", settled, 0); chk("G_after_act", active_lights, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
